// File: rtl/aes_key_init_ctrl_if.sv
// Bundles the software-write, clear, PRNG and key-slot write signals of aes_key_init_ctrl.
// Signal names keep the controller's _i/_o direction suffixes.
interface aes_key_init_ctrl_if #(
  parameter int NumShares = 2,
  parameter int NumWords  = 8
);
  localparam int N      = NumShares * NumWords;
  localparam int ShareW = (NumShares > 1) ? $clog2(NumShares) : 1;
  localparam int IdxW   = (NumWords > 1) ? $clog2(NumWords) : 1;

  logic              sw_req_i;
  logic [ShareW-1:0] sw_share_i;
  logic [IdxW-1:0]   sw_idx_i;
  logic [31:0]       sw_data_i;
  logic              sw_gnt_o;
  logic              clr_i;
  logic              clr_busy_o;
  logic              prng_req_o;
  logic              prng_ack_i;
  logic [31:0]       prng_data_i;
  logic [N-1:0]      key_we_o;
  logic [31:0]       key_wdata_o;
  logic [N-1:0]      written_o;
  logic              key_valid_o;

  modport master (
    output sw_req_i, sw_share_i, sw_idx_i, sw_data_i, clr_i, prng_ack_i, prng_data_i,
    input  sw_gnt_o, clr_busy_o, prng_req_o, key_we_o, key_wdata_o, written_o, key_valid_o
  );

  modport slave (
    input  sw_req_i, sw_share_i, sw_idx_i, sw_data_i, clr_i, prng_ack_i, prng_data_i,
    output sw_gnt_o, clr_busy_o, prng_req_o, key_we_o, key_wdata_o, written_o, key_valid_o
  );
endinterface

// File: rtl/aes_key_init_ctrl.sv
// Key-slot write controller: software loads key words per share; a clear request
// overwrites every slot with PRNG data and invalidates the key.
module aes_key_init_ctrl #(
  parameter int NumShares = 2,
  parameter int NumWords  = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  aes_key_init_ctrl_if.slave bus
);
  localparam int N    = NumShares * NumWords;
  localparam int PtrW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    written_q, written_d;
  logic [N-1:0]    key_we_q, key_we_d;
  logic [31:0]     key_wdata_q, key_wdata_d;
  logic            key_valid_q, key_valid_d;

  // Out-of-range shares (or words) are granted but dropped.
  logic            sw_slot_ok;
  logic [PtrW-1:0] sw_slot;

  always_comb begin
    sw_slot_ok = (int'(bus.sw_share_i) < NumShares) && (int'(bus.sw_idx_i) < NumWords);
    sw_slot    = PtrW'(int'(bus.sw_share_i) * NumWords + int'(bus.sw_idx_i));
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    written_d   = written_q;
    key_we_d    = '0;
    key_wdata_d = key_wdata_q;
    bus.sw_gnt_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.sw_gnt_o = ~bus.clr_i;
        if (bus.clr_i) begin
          state_d   = CLEAR;
          ptr_d     = '0;
          written_d = '0;
        end else if (bus.sw_req_i && sw_slot_ok) begin
          key_we_d           = N'(1) << sw_slot;
          key_wdata_d        = bus.sw_data_i;
          written_d[sw_slot] = 1'b1;
        end
      end

      CLEAR: begin
        if (bus.prng_ack_i) begin
          key_we_d    = N'(1) << ptr_q;
          key_wdata_d = bus.prng_data_i;
          if (ptr_q == PtrW'(N - 1)) begin
            ptr_d   = '0;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    key_valid_d = &written_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      written_q   <= '0;
      key_we_q    <= '0;
      key_wdata_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      written_q   <= written_d;
      key_we_q    <= key_we_d;
      key_wdata_q <= key_wdata_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign bus.clr_busy_o  = (state_q == CLEAR);
  assign bus.prng_req_o  = (state_q == CLEAR);
  assign bus.key_we_o    = key_we_q;
  assign bus.key_wdata_o = key_wdata_q;
  assign bus.written_o   = written_q;
  assign bus.key_valid_o = key_valid_q;

endmodule

// File: tb/tb_aes_key_init_ctrl.sv
// Scoreboard bench for aes_key_init_ctrl: the driver queues expected key writes,
// a negedge monitor matches them against key_we_o/key_wdata_o and their cycle.
module tb_aes_key_init_ctrl;
  localparam int NumShares = 2;
  localparam int NumWords  = 8;
  localparam int N         = NumShares * NumWords;

  typedef struct {
    int          slot;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [N-1:0] exp_written;

  aes_key_init_ctrl_if #(.NumShares(NumShares), .NumWords(NumWords)) bus ();

  aes_key_init_ctrl #(.NumShares(NumShares), .NumWords(NumWords)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every non-zero key_we_o must match the head of the queue at its cycle.
  always @(negedge clk) begin
    if (bus.key_we_o != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.key_we_o), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("write_slot", 64'(bus.key_we_o), 64'(N'(1) << mon_e.slot));
        check("write_data", 64'(bus.key_wdata_o), 64'(mon_e.data));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      check("missing_write", 64'(bus.key_we_o), 64'(N'(1) << mon_e.slot));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int slot, input logic [31:0] data);
    exp_t e;
    e.slot = slot;
    e.data = data;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_written"}, 64'(bus.written_o), 64'(exp_written));
    check({tag, "_valid"}, 64'(bus.key_valid_o), 64'(&exp_written));
  endtask

  task automatic sw_write(input int share, input int idx, input logic [31:0] data);
    bus.sw_req_i   = 1'b1;
    bus.sw_share_i = share[0];
    bus.sw_idx_i   = idx[2:0];
    bus.sw_data_i  = data;
    #1;
    check("sw_gnt", 64'(bus.sw_gnt_o), 64'd1);
    push_exp(share * NumWords + idx, data);
    step();
    bus.sw_req_i = 1'b0;
    exp_written[share * NumWords + idx] = 1'b1;
    check_flags("sw");
  endtask

  // Pulse clr_i, then feed PRNG words 0xA5A5_0000+k; toggle stalls every other cycle.
  task automatic run_clear(input bit toggle, input bit hold_sw);
    int k;
    int it;
    k  = 0;
    it = 0;
    bus.clr_i = 1'b1;
    #1;
    check("clr_gnt_blocked", 64'(bus.sw_gnt_o), 64'd0);
    step();
    bus.clr_i   = 1'b0;
    exp_written = '0;
    check_flags("clr_entry");
    while (k < N && it < 4 * N) begin
      check("clr_busy", 64'(bus.clr_busy_o), 64'd1);
      check("prng_req", 64'(bus.prng_req_o), 64'd1);
      check("clr_written", 64'(bus.written_o), 64'd0);
      if (hold_sw) check("gnt_in_clear", 64'(bus.sw_gnt_o), 64'd0);
      bus.clr_i = toggle && (it == 7);
      if (!toggle || (it % 2 == 0)) begin
        bus.prng_ack_i  = 1'b1;
        bus.prng_data_i = 32'hA5A5_0000 + 32'(k);
        push_exp(k, bus.prng_data_i);
        k++;
      end else begin
        bus.prng_ack_i  = 1'b0;
        bus.prng_data_i = 32'hFFFF_FFFF;
      end
      step();
      it++;
    end
    bus.prng_ack_i = 1'b0;
    bus.clr_i      = 1'b0;
    check("clr_done_busy", 64'(bus.clr_busy_o), 64'd0);
    check("clr_done_req", 64'(bus.prng_req_o), 64'd0);
    check_flags("clr_done");
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    exp_written     = '0;
    rst             = 1'b1;
    bus.sw_req_i    = 1'b0;
    bus.sw_share_i  = '0;
    bus.sw_idx_i    = '0;
    bus.sw_data_i   = '0;
    bus.clr_i       = 1'b0;
    bus.prng_ack_i  = 1'b0;
    bus.prng_data_i = '0;

    repeat (3) step();
    check("rst_we", 64'(bus.key_we_o), 64'd0);
    check("rst_wdata", 64'(bus.key_wdata_o), 64'd0);
    check("rst_busy", 64'(bus.clr_busy_o), 64'd0);
    check("rst_prng_req", 64'(bus.prng_req_o), 64'd0);
    check("rst_gnt", 64'(bus.sw_gnt_o), 64'd1);
    check_flags("rst");
    rst = 1'b0;
    step();

    // Load all 16 slots; key_valid_o must rise only after the last one.
    for (int k = 0; k < N; k++) sw_write(k / NumWords, k % NumWords, 32'h1000_0000 + 32'(k));
    sw_write(0, 2, 32'h1234_5678);

    // Full clear with PRNG always acknowledging.
    run_clear(1'b0, 1'b0);

    // Rewriting a slot adds nothing: bits 3 and 15 only.
    sw_write(0, 3, 32'h0000_0033);
    sw_write(0, 3, 32'h0000_0034);
    sw_write(1, 7, 32'h0000_0F17);
    check("partial_written", 64'(bus.written_o), 64'h8008);
    check("partial_valid", 64'(bus.key_valid_o), 64'd0);

    // clr_i beats a simultaneous sw_req_i; the held request is served after CLEAR.
    bus.sw_req_i   = 1'b1;
    bus.sw_share_i = 1'b1;
    bus.sw_idx_i   = 3'd2;
    bus.sw_data_i  = 32'hDEAD_0001;
    run_clear(1'b0, 1'b1);
    sw_write(1, 2, 32'hDEAD_0001);

    // Stalling PRNG plus a clr_i pulse mid-clear that must be ignored.
    bus.sw_req_i   = 1'b1;
    bus.sw_share_i = 1'b0;
    bus.sw_idx_i   = 3'd5;
    bus.sw_data_i  = 32'hBEEF_0005;
    run_clear(1'b1, 1'b1);
    sw_write(0, 5, 32'hBEEF_0005);

    // Reset after five clear writes aborts the clear with no trailing write.
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.prng_ack_i  = 1'b1;
      bus.prng_data_i = 32'hA5A5_0000 + 32'(k);
      push_exp(k, bus.prng_data_i);
      step();
    end
    rst             = 1'b1;
    bus.prng_data_i = 32'h5555_5555;
    step();
    check("abort_we", 64'(bus.key_we_o), 64'd0);
    check("abort_wdata", 64'(bus.key_wdata_o), 64'd0);
    check("abort_busy", 64'(bus.clr_busy_o), 64'd0);
    check("abort_prng_req", 64'(bus.prng_req_o), 64'd0);
    check("abort_written", 64'(bus.written_o), 64'd0);
    check("abort_valid", 64'(bus.key_valid_o), 64'd0);
    rst            = 1'b0;
    bus.prng_ack_i = 1'b0;
    step();
    run_clear(1'b0, 1'b0);

    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_init_ctrl.md
AES_KEY_INIT_CTRL -- requirements
Module: aes_key_init_ctrl

Interface
REQ-001 Parameter NumShares, default 2, number of key shares.
REQ-002 Parameter NumWords, default 8, 32-bit words per share; total slots N = NumShares*NumWords (16).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 sw_req_i  input  1  software write request.
REQ-006 sw_share_i  input  $clog2(NumShares)  target share of software write.
REQ-007 sw_idx_i  input  $clog2(NumWords)  target word within share.
REQ-008 sw_data_i  input  32  software write data.
REQ-009 sw_gnt_o  output  1  combinational grant; handshake = sw_req_i & sw_gnt_o.
REQ-010 clr_i  input  1  single-cycle request to wipe all key slots.
REQ-011 clr_busy_o  output  1  high while in CLEAR.
REQ-012 prng_req_o  output  1  request for a pseudo-random word.
REQ-013 prng_ack_i  input  1  PRNG handshake; data valid when prng_req_o & prng_ack_i.
REQ-014 prng_data_i  input  32  pseudo-random word.
REQ-015 key_we_o  output  N  registered one-hot write enable; bit s*NumWords+i selects share s, word i.
REQ-016 key_wdata_o  output  32  registered write data accompanying key_we_o.
REQ-017 written_o  output  N  per-slot "written since last clear" flags.
REQ-018 key_valid_o  output  1  registered; high when every bit of written_o is set.

Function
REQ-019 FSM states SHALL be IDLE and CLEAR; reset state IDLE.
REQ-020 In IDLE, sw_gnt_o SHALL equal ~clr_i; in CLEAR, sw_gnt_o SHALL be 0.
REQ-021 On a software handshake, the next cycle SHALL have key_we_o one-hot at slot sw_share_i*NumWords+sw_idx_i and key_wdata_o = sw_data_i (latency 1).
REQ-022 On a software handshake, the written flag of the target slot SHALL be set at the same edge that registers key_we_o.
REQ-023 sw_share_i >= NumShares SHALL be granted but produce no write and no flag change.
REQ-024 clr_i high in IDLE SHALL move to CLEAR, reset the slot pointer to 0 and clear all written flags at that edge; clr_i wins over a simultaneous sw_req_i.
REQ-025 In CLEAR, prng_req_o SHALL be 1; in IDLE, 0.
REQ-026 On each PRNG handshake in CLEAR, the next cycle SHALL write prng_data_i to the slot at the pointer (one-hot key_we_o), and the pointer SHALL increment.
REQ-027 The PRNG handshake at pointer N-1 SHALL return the FSM to IDLE; pointer wraps to 0.
REQ-028 Cycles in CLEAR without prng_ack_i SHALL hold the pointer and produce no write.
REQ-029 clr_i during CLEAR SHALL be ignored; clearing is not restarted.
REQ-030 Clear writes SHALL NOT set written flags; written_o stays 0 through CLEAR.
REQ-031 key_we_o SHALL be all-zero in any cycle not following a handshake; at most one bit is set.
REQ-032 key_valid_o SHALL be registered as the AND of the next-state written flags; rewriting a slot has no further effect.

Reset
REQ-033 On rst_i: state IDLE, pointer 0, written_o 0, key_we_o 0, key_wdata_o 0, key_valid_o 0, clr_busy_o 0, prng_req_o 0.
REQ-034 rst_i asserted mid-CLEAR SHALL abort clearing immediately, with no write in the following cycle.

Verification
REQ-035 Reset, then software writes 0x1000_0000+k to all 16 slots in order -> each write appears one cycle after its handshake; key_valid_o rises the cycle after the 16th handshake.
REQ-036 Full key loaded, pulse clr_i, prng_ack_i held 1 with data 0xA5A5_0000+k -> written_o 0 the next cycle, 16 consecutive one-hot writes to slots 0..15, clr_busy_o high for 16 cycles, key_valid_o 0.
REQ-037 clr_i and sw_req_i in the same IDLE cycle -> sw_gnt_o 0, no software write, CLEAR entered.
REQ-038 CLEAR with prng_ack_i toggling every other cycle -> exactly 16 writes over 32 cycles, pointer stalls on idle cycles; sw_req_i held throughout -> granted only after return to IDLE.
REQ-039 rst_i asserted after 5 clear writes -> all outputs at reset values next cycle; a subsequent clr_i restarts at slot 0.
REQ-040 Write share 0 word 3 twice, then share 1 word 7 -> written_o = 0x8008, key_valid_o 0.
